pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Central PC/pipeline sequencer for the 5-stage core. Arbitrates hazard, redirect and halt
//  requests from ID/EX/memory and drives the PC block's stall, hlt, alt_pc and alt_pc_ctrl
//  controls plus the IF/ID and ID/EX pipeline-register flush/stall strobes.
//  Holds pending redirects across memory stalls and sequences the halt drain.
// PARAMETERS
//  ADDR_W        16  instruction address width (matches PC)
//  DRAIN_CYCLES  3   cycles after HLT leaves ID before the core reports halted (1..15)
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       reset, asynchronous, active-low
//  ext_stall    in   1       memory/multi-cycle stall; freezes whole front end
//  br_taken     in   1       EX resolved taken branch/jump this cycle
//  br_target    in   ADDR_W  EX branch target
//  ld_use_haz   in   1       ID instr depends on load currently in EX
//  hlt_id       in   1       HLT decoded in ID
//  pc_stall     out  1       -> PC stall
//  pc_hlt       out  1       -> PC hlt
//  alt_pc       out  ADDR_W  -> PC alt_pc
//  alt_pc_ctrl  out  1       -> PC alt_pc_ctrl
//  stall_if_id  out  1       hold IF/ID register
//  flush_if_id  out  1       bubble IF/ID register
//  flush_id_ex  out  1       bubble ID/EX register
//  halted       out  1       core halted, sticky until reset
// BEHAVIOUR
//  - Reset: state=RUN, pend_valid=0, pend_target=0, drain_cnt=0; all outputs 0.
//  - State machine: RUN, DRAIN, HALTED. Outputs combinational from state + inputs; regs update on clk.
//  - Priority each cycle: ext_stall > redirect (br_taken or pend_valid) > ld_use_haz > hlt_id.
//  - ext_stall=1: pc_stall=1, stall_if_id=1, no flushes, alt_pc_ctrl=0. If br_taken, latch
//    pend_valid=1, pend_target=br_target; a later br_taken while pending overwrites the target.
//  - Redirect (no ext_stall): alt_pc_ctrl=1, alt_pc=br_taken ? br_target : pend_target
//    (live br_taken wins), pc_stall=0, pc_hlt=0, flush_if_id=1, flush_id_ex=1. Clears pend_valid.
//    Zero-cycle latency: the PC loads the target on the same clk edge.
//  - ld_use_haz (RUN, none above): pc_stall=1, stall_if_id=1, flush_id_ex=1; one bubble per
//    cycle asserted.
//  - hlt_id in RUN (none above): pc_hlt=1, flush_if_id=1, -> DRAIN, drain_cnt=DRAIN_CYCLES-1.
//  - DRAIN: pc_hlt=1, hlt_id/ld_use_haz ignored. drain_cnt decrements only when !ext_stall;
//    at drain_cnt==0 with !ext_stall -> HALTED. Redirect in DRAIN (older branch) cancels
//    the halt: performs redirect, -> RUN, drain_cnt=0.
//  - HALTED: pc_hlt=1, halted=1, every other output 0; all inputs ignored; only rst_n exits.
//  - alt_pc=0 whenever alt_pc_ctrl=0. Never assert alt_pc_ctrl with pc_stall or pc_hlt.
//  - rst_n low mid-operation (pending redirect, drain): immediate return to reset values;
//    the pending target is discarded.
// CONFIGURATION
//  SEQ_PERF_CNT_EN defined: adds outputs stall_cnt[15:0], flush_cnt[15:0]. stall_cnt += 1
//    each cycle pc_stall=1; flush_cnt += 1 each cycle flush_if_id|flush_id_ex. Both saturate
//    at 16'hFFFF, clear on reset, and freeze in HALTED.
//  Not defined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1 br_taken=1, br_target=16'h0040, no stall -> same cycle alt_pc_ctrl=1, alt_pc=0040,
//    flush_if_id=flush_id_ex=1; PC=0040 next edge.
//  2 ext_stall=1 + br_taken (target 0x0123) for 3 cycles, then ext_stall=0, br_taken=0
//    -> pc_stall=1 x3, then one cycle alt_pc_ctrl=1, alt_pc=0123; pend_valid clear after.
//  3 ld_use_haz=1 for 1 cycle -> pc_stall=stall_if_id=flush_id_ex=1 for exactly 1 cycle;
//    PC holds value.
//  4 hlt_id=1, DRAIN_CYCLES=3, one ext_stall cycle during drain -> pc_hlt from cycle 0,
//    halted=1 after 4 cycles; sticky under further input activity.
//  5 hlt_id, then br_taken (target 0x0010) on next cycle -> halt cancelled, redirect to 0010,
//    state RUN, halted never 1.
//  6 Reset asserted during pending redirect -> all outputs 0 asynchronously; after release,
//    no redirect occurs.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// pc_sequencer: arbitrates stall/redirect/halt requests into PC and pipeline-register controls.
// Optional performance counters are built when SEQ_PERF_CNT_EN is defined.
module pc_sequencer #(
   parameter int ADDR_W       = 16,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ext_stall,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              ld_use_haz,
   input  logic              hlt_id,
   output logic              pc_stall,
   output logic              pc_hlt,
   output logic [ADDR_W-1:0] alt_pc,
   output logic              alt_pc_ctrl,
   output logic              stall_if_id,
   output logic              flush_if_id,
   output logic              flush_id_ex,
`ifdef SEQ_PERF_CNT_EN
   output logic [15:0]       stall_cnt,
   output logic [15:0]       flush_cnt,
`endif
   output logic              halted
);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_DRAIN  = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   localparam logic [3:0] C_DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

   state_t              r_state, w_state_nxt;
   logic                r_pend_valid, w_pend_valid_nxt;
   logic [ADDR_W-1:0]   r_pend_target, w_pend_target_nxt;
   logic [3:0]          r_drain_cnt, w_drain_cnt_nxt;

   logic                w_pc_stall, w_pc_hlt, w_alt_pc_ctrl, w_stall_if_id;
   logic                w_flush_if_id, w_flush_id_ex, w_halted;
   logic [ADDR_W-1:0]   w_alt_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_RUN;
         r_pend_valid  <= 1'b0;
         r_pend_target <= '0;
         r_drain_cnt   <= 4'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_pend_valid  <= w_pend_valid_nxt;
         r_pend_target <= w_pend_target_nxt;
         r_drain_cnt   <= w_drain_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_pend_valid_nxt  = r_pend_valid;
      w_pend_target_nxt = r_pend_target;
      w_drain_cnt_nxt   = r_drain_cnt;
      w_pc_stall        = 1'b0;
      w_pc_hlt          = 1'b0;
      w_alt_pc_ctrl     = 1'b0;
      w_alt_pc          = '0;
      w_stall_if_id     = 1'b0;
      w_flush_if_id     = 1'b0;
      w_flush_id_ex     = 1'b0;
      w_halted          = 1'b0;
      case (r_state)
         S_HALTED: begin
            w_pc_hlt = 1'b1;
            w_halted = 1'b1;
         end
         default: begin
            if (ext_stall) begin
               // Front end frozen; a branch resolving now must survive until the stall lifts.
               w_pc_stall    = 1'b1;
               w_stall_if_id = 1'b1;
               w_pc_hlt      = (r_state == S_DRAIN);
               if (br_taken) begin
                  w_pend_valid_nxt  = 1'b1;
                  w_pend_target_nxt = br_target;
               end
            end else if (br_taken || r_pend_valid) begin
               w_alt_pc_ctrl    = 1'b1;
               w_alt_pc         = br_taken ? br_target : r_pend_target;
               w_flush_if_id    = 1'b1;
               w_flush_id_ex    = 1'b1;
               w_pend_valid_nxt = 1'b0;
               w_state_nxt      = S_RUN;
               w_drain_cnt_nxt  = 4'd0;
            end else if (r_state == S_DRAIN) begin
               w_pc_hlt = 1'b1;
               if (r_drain_cnt == 4'd0) begin
                  w_state_nxt = S_HALTED;
               end else begin
                  w_drain_cnt_nxt = r_drain_cnt - 4'd1;
               end
            end else if (ld_use_haz) begin
               w_pc_stall    = 1'b1;
               w_stall_if_id = 1'b1;
               w_flush_id_ex = 1'b1;
            end else if (hlt_id) begin
               w_pc_hlt        = 1'b1;
               w_flush_if_id   = 1'b1;
               w_state_nxt     = S_DRAIN;
               w_drain_cnt_nxt = C_DRAIN_INIT;
            end
         end
      endcase
   end

   // Outputs are forced low for the whole reset assertion, not just until the next edge.
   assign pc_stall    = rst_n & w_pc_stall;
   assign pc_hlt      = rst_n & w_pc_hlt;
   assign alt_pc_ctrl = rst_n & w_alt_pc_ctrl;
   assign alt_pc      = rst_n ? w_alt_pc : '0;
   assign stall_if_id = rst_n & w_stall_if_id;
   assign flush_if_id = rst_n & w_flush_if_id;
   assign flush_id_ex = rst_n & w_flush_id_ex;
   assign halted      = rst_n & w_halted;

`ifdef SEQ_PERF_CNT_EN
   logic [15:0] r_stall_cnt, r_flush_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= 16'd0;
         r_flush_cnt <= 16'd0;
      end else if (r_state != S_HALTED) begin
         if (w_pc_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
         if ((w_flush_if_id || w_flush_id_ex) && (r_flush_cnt != 16'hFFFF)) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire
